// File: rtl/n64_poll_scheduler.sv
// n64_poll_scheduler: APB3-controlled scheduler that periodically commands the
// N64 controller interface engine to poll, latches the returned button/stick
// word, and flags engine timeouts.
// Optional build macro: N64_CHANGE_IRQ_EN adds a STATUS.change flag, which is
// set when a new sample differs from the previous one, plus CTRL.irq_en and
// the irq output.
// The tick counter holds the number of PCLK cycles since the last poll_start
// pulse. That pulse is registered, so it is high in the cycle where cnt == 0.
module n64_poll_scheduler #(
  parameter int TICKS_PER_MICRO = 25,
  parameter int POLL_PERIOD_US  = 1000,
  parameter int TIMEOUT_US      = 200
) (
  input  logic        PCLK,
  input  logic        PRESERN,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        poll_start,
  input  logic        poll_busy,
  input  logic        poll_done,
  input  logic [31:0] poll_data,
  output logic        irq
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  localparam logic [31:0] TPM     = 32'(TICKS_PER_MICRO);
  // The last counter value at which a response is still accepted. The flag
  // becomes visible exactly TIMEOUT_US*TICKS_PER_MICRO cycles after poll_start.
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_US * TICKS_PER_MICRO - 1);

  logic [1:0]  state;
  logic [31:0] cnt;
  logic [31:0] data_q;
  logic [15:0] period_q;
  logic        ctrl_en;
  logic        trig_q;
  logic        sts_to;
  logic        poll_start_q;
  logic        irq_en;
  logic        sts_chg;

  logic        wr;
  logic        wr_ctrl;
  logic        wr_sts;
  logic        wr_per;
  logic [15:0] per_eff;
  logic [31:0] gap_ticks;
  logic        gap_hit;
  logic        to_hit;
  logic        latch;
  logic        to_set;

  assign PREADY     = 1'b1;
  assign PSLVERR    = 1'b0;
  assign poll_start = poll_start_q;

  assign wr      = PSEL & PENABLE & PWRITE;
  assign wr_ctrl = wr & (PADDR[3:2] == 2'd0);
  assign wr_sts  = wr & (PADDR[3:2] == 2'd1);
  assign wr_per  = wr & (PADDR[3:2] == 2'd3);

  // A PERIOD of zero behaves like a PERIOD of one. The GAP state exits two
  // ticks early because of the START cycle and the registered poll_start, so
  // poll_start pulses are spaced exactly gap_ticks apart.
  assign per_eff   = (period_q == 16'd0) ? 16'd1 : period_q;
  assign gap_ticks = 32'(per_eff) * TPM;
  assign gap_hit   = ({1'b0, cnt} + 33'd2) >= {1'b0, gap_ticks};
  assign to_hit    = cnt >= TO_LAST;
  // A response that arrives in the timeout cycle still counts as a response.
  assign latch     = (state == S_WAIT) & poll_done;
  assign to_set    = (state == S_WAIT) & ~poll_done & to_hit;

  // CTRL, PERIOD and the sticky timeout flag. A flag that is set and cleared
  // in the same cycle stays set.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      ctrl_en  <= 1'b0;
      trig_q   <= 1'b0;
      period_q <= 16'(POLL_PERIOD_US);
      sts_to   <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_en <= PWDATA[0];
      trig_q <= wr_ctrl & PWDATA[1];
      if (wr_per) period_q <= PWDATA[15:0];
      sts_to <= to_set | (sts_to & ~(wr_sts & PWDATA[1]));
    end
  end

  // Poll sequencer: issue the request, wait for the response or a timeout,
  // then hold until the period elapses.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      state        <= S_IDLE;
      cnt          <= 32'd0;
      data_q       <= 32'd0;
      poll_start_q <= 1'b0;
    end else begin
      poll_start_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ctrl_en | trig_q) state <= S_START;
        end
        S_START: begin
          if (!poll_busy) begin
            poll_start_q <= 1'b1;
            cnt          <= 32'd0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 32'd1;
          if (poll_done) begin
            data_q <= poll_data;
            state  <= S_GAP;
          end else if (to_hit) begin
            state  <= S_GAP;
          end
        end
        S_GAP: begin
          cnt <= cnt + 32'd1;
          if (gap_hit) state <= ctrl_en ? S_START : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef N64_CHANGE_IRQ_EN
  logic irq_en_q;
  logic chg_q;
  logic have_data;

  // Change detection. The first sample after reset becomes the baseline and
  // does not raise a change.
  always_ff @(posedge PCLK or negedge PRESERN) begin
    if (!PRESERN) begin
      irq_en_q  <= 1'b0;
      chg_q     <= 1'b0;
      have_data <= 1'b0;
    end else begin
      if (wr_ctrl) irq_en_q <= PWDATA[2];
      if (latch) have_data <= 1'b1;
      chg_q <= (latch & have_data & (poll_data != data_q))
             | (chg_q & ~(wr_sts & PWDATA[2]));
    end
  end

  assign irq_en  = irq_en_q;
  assign sts_chg = chg_q;
  assign irq     = (chg_q | sts_to) & irq_en_q;
`else
  logic unused_cfg;
  assign unused_cfg = PWDATA[2] ^ latch;
  assign irq_en  = 1'b0;
  assign sts_chg = 1'b0;
  assign irq     = 1'b0;
`endif

  logic unused_addr;
  assign unused_addr = ^{PADDR[31:4], PADDR[1:0], PWDATA[31:16]};

  // Combinational read mux. It drives zero whenever the bus is not selected.
  always_comb begin
    PRDATA = 32'd0;
    if (PSEL) begin
      case (PADDR[3:2])
        2'd0:    PRDATA = {29'd0, irq_en, 1'b0, ctrl_en};
        2'd1:    PRDATA = {29'd0, sts_chg, sts_to, (state != S_IDLE)};
        2'd2:    PRDATA = data_q;
        2'd3:    PRDATA = {16'd0, period_q};
        default: PRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_poll_scheduler.sv
// tb_n64_poll_scheduler: register vectors from a table, followed by directed
// sequences for periodic polling, timeout, busy hold-off, mid-poll reset and
// change/irq behaviour.
module tb_n64_poll_scheduler;

`ifdef N64_CHANGE_IRQ_EN
  localparam logic CHG = 1'b1;
`else
  localparam logic CHG = 1'b0;
`endif

  logic        PCLK = 1'b0;
  logic        PRESERN = 1'b0;
  logic        PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
  logic [31:0] PADDR = 32'd0, PWDATA = 32'd0;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR, poll_start, irq;
  logic        poll_busy = 1'b0;
  logic        poll_done = 1'b0;
  logic [31:0] poll_data = 32'd0;

  n64_poll_scheduler dut (
    .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .poll_start(poll_start),
    .poll_busy(poll_busy), .poll_done(poll_done), .poll_data(poll_data),
    .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc <= cyc + 1;

  // Engine model: a response arrives eng_lat cycles after poll_start.
  int          ps_cnt = 0, ps_last = 0, ps_prev = 0;
  int          eng_left = 0, eng_lat = 40;
  bit          eng_en = 1'b0;
  logic [31:0] eng_data = 32'd0;
  always @(negedge PCLK) begin
    poll_done = 1'b0;
    if (eng_left > 0) begin
      eng_left--;
      if (eng_left == 0) begin
        poll_done = 1'b1;
        poll_data = eng_data;
      end
    end
    if (poll_start) begin
      ps_prev = ps_last;
      ps_last = cyc;
      ps_cnt++;
      if (eng_en) eng_left = eng_lat;
    end
  end

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tmo(input string name);
    n_tot++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic apb_wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b1; PADDR = a; PWDATA = d; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
  endtask

  task automatic apb_rd(input logic [31:0] a, output logic [31:0] d);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PADDR = a; PENABLE = 1'b0;
    @(negedge PCLK);
    PENABLE = 1'b1;
    #1 d = PRDATA;
    @(negedge PCLK);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wait_ps(input int target, input int budget, input string name);
    for (int i = 0; i < budget && ps_cnt < target; i++) @(posedge PCLK);
    @(negedge PCLK);
    if (ps_cnt < target) tmo(name);
  endtask

  task automatic wait_idle(input int budget, input string name);
    logic [31:0] s;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      apb_rd(32'h4, s);
      if (!s[0]) begin ok = 1'b1; break; end
    end
    if (!ok) tmo(name);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt[15];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int c0, t0, b0;
    logic [31:0] seq_data [3];

    vt[0]  = '{1'b0, 32'h0, 32'h0,        32'h0,                 "ctrl_rst"};
    vt[1]  = '{1'b0, 32'h4, 32'h0,        32'h0,                 "status_rst"};
    vt[2]  = '{1'b0, 32'h8, 32'h0,        32'h0,                 "data_rst"};
    vt[3]  = '{1'b0, 32'hC, 32'h0,        32'h3E8,               "period_rst"};
    vt[4]  = '{1'b1, 32'hC, 32'hABCD1234, 32'h0,                 ""};
    vt[5]  = '{1'b0, 32'hC, 32'h0,        32'h1234,              "period_16b"};
    vt[6]  = '{1'b1, 32'h8, 32'hFFFFFFFF, 32'h0,                 ""};
    vt[7]  = '{1'b0, 32'h8, 32'h0,        32'h0,                 "data_ro"};
    vt[8]  = '{1'b1, 32'h0, 32'h4,        32'h0,                 ""};
    vt[9]  = '{1'b0, 32'h0, 32'h0,        {29'd0, CHG, 2'd0},    "ctrl_irq_en"};
    vt[10] = '{1'b1, 32'h0, 32'h0,        32'h0,                 ""};
    vt[11] = '{1'b1, 32'h4, 32'h6,        32'h0,                 ""};
    vt[12] = '{1'b0, 32'h4, 32'h0,        32'h0,                 "status_idle"};
    vt[13] = '{1'b1, 32'hC, 32'h0,        32'h0,                 ""};
    vt[14] = '{1'b0, 32'hC, 32'h0,        32'h0,                 "period_zero"};

    // Outputs while reset is held
    #22;
    chk("rst_poll_start", poll_start, 0);
    chk("rst_irq", irq, 0);
    chk("pready", PREADY, 1);
    chk("pslverr", PSLVERR, 0);
    @(negedge PCLK);
    PRESERN = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (vt[i].wr) apb_wr(vt[i].addr, vt[i].data);
      else begin
        apb_rd(vt[i].addr, r);
        chk(vt[i].name, r, vt[i].exp);
      end
    end
    chk("no_poll_idle", ps_cnt, 0);

    // Periodic polling: PERIOD=10 us gives 250 cycles between pulses
    c0 = ps_cnt;
    eng_en = 1'b1; eng_lat = 40; eng_data = 32'h3;
    apb_wr(32'hC, 32'd10);
    apb_wr(32'h0, 32'h1);
    wait_ps(c0 + 1, 100, "ps_first");
    for (int k = 1; k <= 3; k++) begin
      wait_ps(c0 + 1 + k, 400, "ps_periodic");
      chk("period_interval", 32'(ps_last - ps_prev), 32'd250);
    end
    apb_rd(32'h8, r);
    chk("data_periodic", r, 32'h3);
    PADDR = 32'h8; PSEL = 1'b0;
    #1 chk("prdata_unselected", PRDATA, 0);

    // Clearing enable mid-poll still completes the transaction
    eng_data = 32'h7;
    wait_ps(c0 + 5, 400, "ps_last_enabled");
    apb_wr(32'h0, 32'h0);
    wait_idle(200, "idle_after_disable");
    apb_rd(32'h8, r);
    chk("data_after_disable", r, 32'h7);
    repeat (300) @(negedge PCLK);
    chk("no_ps_disabled", ps_cnt, c0 + 5);

    // Single trigger with a silent engine leads to a timeout
    eng_en = 1'b0;
    c0 = ps_cnt;
    apb_wr(32'h0, 32'h2);
    wait_ps(c0 + 1, 20, "ps_trigger");
    t0 = ps_last;
    apb_wr(32'h0, 32'h2);
    @(negedge PCLK);
    PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b0; PADDR = 32'h4;
    while (cyc < t0 + 4999) @(negedge PCLK);
    chk("timeout_not_yet", PRDATA[1], 0);
    @(negedge PCLK);
    chk("timeout_set", PRDATA[1], 1);
    PSEL = 1'b0;
    repeat (5) @(negedge PCLK);
    apb_rd(32'h4, r);
    chk("timeout_idle_status", r & 32'h3, 32'h2);
    chk("single_ps", ps_cnt, c0 + 1);
    apb_rd(32'h8, r);
    chk("data_kept_on_timeout", r, 32'h7);
    apb_rd(32'h0, r);
    chk("trigger_reads0", r, 0);
    apb_wr(32'h4, 32'h6);
    apb_rd(32'h4, r);
    chk("timeout_w1c", r & 32'h3, 0);

    // Response that coincides with the timeout cycle counts as done
    eng_en = 1'b1; eng_lat = 4999; eng_data = 32'hA5A5A5A5;
    c0 = ps_cnt;
    apb_wr(32'h0, 32'h2);
    wait_ps(c0 + 1, 20, "ps_coincident");
    wait_idle(2500, "idle_coincident");
    apb_rd(32'h8, r);
    chk("data_coincident", r, 32'hA5A5A5A5);
    apb_rd(32'h4, r);
    chk("no_timeout_coincident", r & 32'h3, 0);

    // poll_busy holds off poll_start
    eng_lat = 40; eng_data = 32'h55;
    poll_busy = 1'b1;
    c0 = ps_cnt;
    apb_wr(32'h0, 32'h2);
    repeat (100) @(negedge PCLK);
    chk("busy_holdoff", ps_cnt, c0);
    apb_rd(32'h4, r);
    chk("busy_in_start", r[0], 1);
    @(negedge PCLK);
    poll_busy = 1'b0;
    b0 = cyc;
    wait_ps(c0 + 1, 10, "ps_after_busy");
    chk("ps_after_busy_cycle", ps_last, b0 + 1);

    // Reset pulse in the middle of WAIT_DONE
    repeat (5) @(negedge PCLK);
    PRESERN = 1'b0;
    #1;
    chk("rst_mid_ps", poll_start, 0);
    chk("rst_mid_irq", irq, 0);
    apb_rd(32'h0, r); chk("rst_mid_ctrl", r, 0);
    apb_rd(32'h4, r); chk("rst_mid_status", r, 0);
    apb_rd(32'h8, r); chk("rst_mid_data", r, 0);
    apb_rd(32'hC, r); chk("rst_mid_period", r, 32'd1000);
    @(negedge PCLK);
    PRESERN = 1'b1;
    repeat (100) @(negedge PCLK);
    chk("idle_after_rst", ps_cnt, c0 + 1);
    apb_rd(32'h4, r); chk("status_after_rst", r, 0);
    apb_rd(32'h8, r); chk("late_done_ignored", r, 0);

    // Change detection and irq: samples 1, 1, 2
    seq_data[0] = 32'h1; seq_data[1] = 32'h1; seq_data[2] = 32'h2;
    apb_wr(32'hC, 32'd1);
    for (int i = 0; i < 3; i++) begin
      eng_data = seq_data[i];
      c0 = ps_cnt;
      apb_wr(32'h0, 32'h6);
      wait_ps(c0 + 1, 20, "ps_change");
      wait_idle(100, "idle_change");
      apb_rd(32'h4, r);
      chk("change_flag", r[2], (i == 2) ? CHG : 1'b0);
      chk("irq_level", irq, (i == 2) ? CHG : 1'b0);
    end
    apb_rd(32'h8, r);
    chk("data_change_seq", r, 32'h2);
    apb_wr(32'h4, 32'h4);
    chk("irq_cleared", irq, 0);
    apb_rd(32'h4, r);
    chk("change_w1c", r[2], 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
